// File: rtl/br_escrita_fila.sv
// ---------------------------------------------------------------------------
// br_escrita_fila
// Write-side sequencer for the register bank. Write requests from the
// datapath are accepted over a valid/ready handshake into a small in-order
// FIFO. Entries are drained into the bank write port at up to one write per
// cycle. Hazard flags tell the control unit when a read address still has a
// write queued or being issued.
//
// Build option:
//   BR_ESCRITA_FWD_EN  adds fwd_a / fwd_b. Each carries the data of the
//                      youngest pending write to Sel_SA / Sel_SB, or 0 when
//                      there is none.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   limpa        synchronous flush of all queued writes
//   pausa        hold draining; no bank write is issued while high
//   req_valid    write request valid
//   req_ready    FIFO can accept a request (not full)
//   req_end      destination register address
//   req_dado     data to write
//   Hab_Escrita  bank write enable (registered)
//   Sel_SC       bank write address (registered)
//   E            bank write data (registered)
//   Sel_SA       bank read address A, used for the hazard check
//   Sel_SB       bank read address B, used for the hazard check
//   pend_a       a write to Sel_SA is queued or being issued
//   pend_b       a write to Sel_SB is queued or being issued
//   fila_vazia   FIFO empty
//   fila_cheia   FIFO full
//   fila_nivel   FIFO occupancy
//   fwd_a/fwd_b  youngest pending data for Sel_SA/Sel_SB (option only)
//
// State | meaning
// ------+---------------------------------------------------------------
// OCIOSO   | FIFO empty, nothing to issue
// DRENANDO | popping one entry per cycle onto the bank write port
// PAUSADO  | pausa held; entries stay queued, no writes are issued
// ---------------------------------------------------------------------------
module br_escrita_fila #(
  parameter int BITS_PALAVRA  = 16,
  parameter int END_REGISTROS = 2,
  parameter int PROF_FILA     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       limpa,
  input  logic                       pausa,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [END_REGISTROS-1:0]   req_end,
  input  logic [BITS_PALAVRA-1:0]    req_dado,
  output logic                       Hab_Escrita,
  output logic [END_REGISTROS-1:0]   Sel_SC,
  output logic [BITS_PALAVRA-1:0]    E,
  input  logic [END_REGISTROS-1:0]   Sel_SA,
  input  logic [END_REGISTROS-1:0]   Sel_SB,
  output logic                       pend_a,
  output logic                       pend_b,
  output logic                       fila_vazia,
  output logic                       fila_cheia,
  output logic [$clog2(PROF_FILA):0] fila_nivel
`ifdef BR_ESCRITA_FWD_EN
  ,
  output logic [BITS_PALAVRA-1:0]    fwd_a,
  output logic [BITS_PALAVRA-1:0]    fwd_b
`endif
);

  localparam int PTR_W = $clog2(PROF_FILA);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DRENANDO = 2'd1,
    PAUSADO  = 2'd2
  } estado_t;

  estado_t                  estado;
  logic [END_REGISTROS-1:0] mem_end  [PROF_FILA];
  logic [BITS_PALAVRA-1:0]  mem_dado [PROF_FILA];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic                     push;
  logic                     pop;
  logic [PTR_W-1:0]         idx;

  assign fila_cheia = (count == CNT_W'(PROF_FILA));
  assign fila_vazia = (count == '0);
  assign fila_nivel = count;
  // No full-bypass: a same-cycle pop does not open a slot for the push.
  assign req_ready  = !fila_cheia;

  // Flush wins over both push and pop.
  assign push = req_valid && req_ready && !limpa;
  assign pop  = !limpa && !pausa && (count != '0);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Storage carries no reset; only entries inside the count are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_end[wr_ptr]  <= req_end;
      mem_dado[wr_ptr] <= req_dado;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      Hab_Escrita <= 1'b0;
      Sel_SC      <= '0;
      E           <= '0;
    end else if (limpa) begin
      // A write already on the port this cycle is sampled by the bank at
      // this edge; only the queue and the next cycle's enable are dropped.
      estado      <= OCIOSO;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      Hab_Escrita <= 1'b0;
    end else begin
      count       <= count_next;
      Hab_Escrita <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        Sel_SC <= mem_end[rd_ptr];
        E      <= mem_dado[rd_ptr];
      end
      case (estado)
        OCIOSO: begin
          if (count_next != '0) begin
            estado <= DRENANDO;
          end
        end
        DRENANDO: begin
          if (pausa) begin
            estado <= PAUSADO;
          end else if (count_next == '0) begin
            estado <= OCIOSO;
          end
        end
        PAUSADO: begin
          if (!pausa) begin
            estado <= (count_next == '0) ? OCIOSO : DRENANDO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Hazard scan, oldest to youngest, so the last match is the youngest.
  // The issuing register is older than anything still in the FIFO, so it
  // seeds the search.
  always_comb begin
    idx    = rd_ptr;
    pend_a = Hab_Escrita && (Sel_SC == Sel_SA);
    pend_b = Hab_Escrita && (Sel_SC == Sel_SB);
`ifdef BR_ESCRITA_FWD_EN
    fwd_a  = pend_a ? E : '0;
    fwd_b  = pend_b ? E : '0;
`endif
    for (int k = 0; k < PROF_FILA; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (mem_end[idx] == Sel_SA) begin
          pend_a = 1'b1;
`ifdef BR_ESCRITA_FWD_EN
          fwd_a  = mem_dado[idx];
`endif
        end
        if (mem_end[idx] == Sel_SB) begin
          pend_b = 1'b1;
`ifdef BR_ESCRITA_FWD_EN
          fwd_b  = mem_dado[idx];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_br_escrita_fila.sv
// ---------------------------------------------------------------------------
// tb_br_escrita_fila
// Self-checking bench for br_escrita_fila. A queue-based reference model
// tracks the pending writes and the bank port; every cycle the DUT outputs
// are compared against it, with directed checks at the key scenario points.
// ---------------------------------------------------------------------------
module tb_br_escrita_fila;

  localparam int BP = 16;
  localparam int ER = 2;
  localparam int PF = 4;
  localparam int NW = $clog2(PF) + 1;

  logic          clock     = 1'b0;
  logic          reset     = 1'b0;
  logic          limpa     = 1'b0;
  logic          pausa     = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [ER-1:0] req_end   = '0;
  logic [BP-1:0] req_dado  = '0;
  logic          Hab_Escrita;
  logic [ER-1:0] Sel_SC;
  logic [BP-1:0] E;
  logic [ER-1:0] Sel_SA    = '0;
  logic [ER-1:0] Sel_SB    = '0;
  logic          pend_a;
  logic          pend_b;
  logic          fila_vazia;
  logic          fila_cheia;
  logic [NW-1:0] fila_nivel;
`ifdef BR_ESCRITA_FWD_EN
  logic [BP-1:0] fwd_a;
  logic [BP-1:0] fwd_b;
`endif

  br_escrita_fila #(
    .BITS_PALAVRA (BP),
    .END_REGISTROS(ER),
    .PROF_FILA    (PF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .limpa      (limpa),
    .pausa      (pausa),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_end    (req_end),
    .req_dado   (req_dado),
    .Hab_Escrita(Hab_Escrita),
    .Sel_SC     (Sel_SC),
    .E          (E),
    .Sel_SA     (Sel_SA),
    .Sel_SB     (Sel_SB),
    .pend_a     (pend_a),
    .pend_b     (pend_b),
    .fila_vazia (fila_vazia),
    .fila_cheia (fila_cheia),
    .fila_nivel (fila_nivel)
`ifdef BR_ESCRITA_FWD_EN
    ,
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: pending writes in arrival order plus the bank port.
  logic [ER-1:0] m_end  [$];
  logic [BP-1:0] m_dado [$];
  logic          m_hab = 1'b0;
  logic [ER-1:0] m_sc  = '0;
  logic [BP-1:0] m_e   = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_end.delete();
    m_dado.delete();
    m_hab = 1'b0;
    m_sc  = '0;
    m_e   = '0;
  endtask

  // Youngest pending data for a read address: oldest is the bank port,
  // then the queue from front (oldest) to back (youngest).
  task automatic model_pend(input logic [ER-1:0] a, output logic p, output logic [BP-1:0] d);
    p = m_hab && (m_sc == a);
    d = p ? m_e : '0;
    foreach (m_end[i]) begin
      if (m_end[i] == a) begin
        p = 1'b1;
        d = m_dado[i];
      end
    end
  endtask

  task automatic check_all();
    int            lvl;
    logic          pa, pb;
    logic [BP-1:0] da, db;
    lvl = m_end.size();
    model_pend(Sel_SA, pa, da);
    model_pend(Sel_SB, pb, db);
    chk("hab",    32'(Hab_Escrita), 32'(m_hab));
    chk("sel_sc", 32'(Sel_SC),      32'(m_sc));
    chk("e",      32'(E),           32'(m_e));
    chk("nivel",  32'(fila_nivel),  32'(lvl));
    chk("vazia",  32'(fila_vazia),  32'(lvl == 0));
    chk("cheia",  32'(fila_cheia),  32'(lvl == PF));
    chk("ready",  32'(req_ready),   32'(lvl < PF));
    chk("pend_a", 32'(pend_a),      32'(pa));
    chk("pend_b", 32'(pend_b),      32'(pb));
`ifdef BR_ESCRITA_FWD_EN
    chk("fwd_a",  32'(fwd_a),       32'(da));
    chk("fwd_b",  32'(fwd_b),       32'(db));
`endif
  endtask

  task automatic model_edge();
    logic psh;
    psh = req_valid && (m_end.size() < PF);
    if (limpa) begin
      m_end.delete();
      m_dado.delete();
      m_hab = 1'b0;
    end else begin
      if (!pausa && m_end.size() > 0) begin
        m_hab = 1'b1;
        m_sc  = m_end.pop_front();
        m_e   = m_dado.pop_front();
      end else begin
        m_hab = 1'b0;
      end
      if (psh) begin
        m_end.push_back(req_end);
        m_dado.push_back(req_dado);
      end
    end
  endtask

  // One clock cycle: drive, check settled outputs, clock, update model.
  task automatic step(input logic v, input logic [ER-1:0] en, input logic [BP-1:0] d,
                      input logic p, input logic l);
    req_valid = v;
    req_end   = en;
    req_dado  = d;
    pausa     = p;
    limpa     = l;
    #1;
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [BP-1:0] ord [4];

  initial begin
    ord[0] = 16'h0011; ord[1] = 16'h0022; ord[2] = 16'h0033; ord[3] = 16'h0044;
    model_reset();

    // Reset values.
    #2;
    check_all();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single push; write appears exactly one cycle after acceptance.
    step(1'b1, 2'd2, 16'h00A5, 1'b0, 1'b0);
    chk("lat_hab_pre", 32'(Hab_Escrita), 32'(0));
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("lat_hab", 32'(Hab_Escrita), 32'(1));
    chk("lat_sc",  32'(Sel_SC), 32'(2));
    chk("lat_e",   32'(E), 32'h00A5);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("lat_vazia",  32'(fila_vazia), 32'(1));
    chk("lat_hab_lo", 32'(Hab_Escrita), 32'(0));

    // Fill while paused; 5th request ignored; release drains in order.
    for (int i = 0; i < 4; i++) step(1'b1, ER'(i), ord[i], 1'b1, 1'b0);
    chk("full_ready", 32'(req_ready), 32'(0));
    chk("full_cheia", 32'(fila_cheia), 32'(1));
    step(1'b1, 2'd1, 16'h0055, 1'b1, 1'b0);
    chk("full_nivel", 32'(fila_nivel), 32'(PF));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      chk("ord_hab", 32'(Hab_Escrita), 32'(1));
      chk("ord_e",   32'(E), 32'(ord[i]));
    end
    idle(2);

    // Continuous push and drain; level holds at 1 through pointer wrap.
    step(1'b1, ER'($urandom_range(0, 3)), BP'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ER'($urandom_range(0, 3)), BP'($urandom), 1'b0, 1'b0);
      chk("stream_nivel", 32'(fila_nivel), 32'(1));
      chk("stream_hab",   32'(Hab_Escrita), 32'(1));
    end
    idle(3);

    // Hazard flags.
    Sel_SA = 2'd3;
    Sel_SB = 2'd1;
    step(1'b1, 2'd3, 16'h0077, 1'b1, 1'b0);
    chk("haz_a_q", 32'(pend_a), 32'(1));
    chk("haz_b_q", 32'(pend_b), 32'(0));
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("haz_a_iss", 32'(pend_a), 32'(1));
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("haz_a_done", 32'(pend_a), 32'(0));

    // Flush with a same-cycle push.
    for (int i = 0; i < 3; i++) step(1'b1, ER'(i), BP'(16'h0100 + i), 1'b1, 1'b0);
    step(1'b1, 2'd3, 16'h0BAD, 1'b0, 1'b1);
    chk("flush_nivel", 32'(fila_nivel), 32'(0));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      chk("flush_hab", 32'(Hab_Escrita), 32'(0));
    end

`ifdef BR_ESCRITA_FWD_EN
    // Forwarding picks the youngest of two writes to the same register.
    step(1'b1, 2'd1, 16'h0005, 1'b1, 1'b0);
    step(1'b1, 2'd1, 16'h0009, 1'b1, 1'b0);
    Sel_SA = 2'd1;
    #1;
    chk("fwd_young", 32'(fwd_a), 32'h0009);
    idle(4);
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      Sel_SA = ER'($urandom_range(0, 3));
      Sel_SB = ER'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), ER'($urandom_range(0, 3)), BP'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(6);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, BP'(16'h0200 + i), 1'b1, 1'b0);
    Sel_SA = 2'd2;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_pre_hab", 32'(Hab_Escrita), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_hab",   32'(Hab_Escrita), 32'(0));
    chk("rst_nivel", 32'(fila_nivel), 32'(0));
    chk("rst_vazia", 32'(fila_vazia), 32'(1));
    chk("rst_cheia", 32'(fila_cheia), 32'(0));
    chk("rst_pend",  32'(pend_a), 32'(0));
    chk("rst_sc",    32'(Sel_SC), 32'(0));
    chk("rst_e",     32'(E), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 2'd0, 16'h1234, 1'b0, 1'b0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
